// File: rtl/tcam_lookup_sched.sv
// tcam_lookup_sched
// Command scheduler in front of the TCAM Mem stage. Write, flush and lookup
// requests arrive on a valid/ready port and are queued in a small FIFO. They
// are issued to the Mem MODE/operand pins one at a time. A lookup waits out
// the Mem compare latency, captures DstID_Out and returns it with the request
// tag on a valid/ready response port.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/req_ready       request handshake
//   req_op                    0=lookup 1=write 2=flush 3=reserved (dropped)
//   req_tag, req_id           lookup tag and key
//   req_data/mask/addr/vbi    write operands
//   rsp_valid/rsp_ready       response handshake
//   rsp_tag, rsp_dst, rsp_hit lookup result (dst 0 = miss)
//   mem_*                     registered Mem stage drive; mem_dst_id is Mem result
module tcam_lookup_sched #(
  parameter int ID_Width    = 4,
  parameter int AddressSize = 4,
  parameter int TAG_W       = 4,
  parameter int FIFO_DEPTH  = 4,
  parameter int CMP_WAIT    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [TAG_W-1:0]       req_tag,
  input  logic [ID_Width-1:0]    req_id,
  input  logic [2*ID_Width-1:0]  req_data,
  input  logic [2*ID_Width-1:0]  req_mask,
  input  logic [AddressSize-1:0] req_addr,
  input  logic                   req_vbi,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [ID_Width-1:0]    rsp_dst,
  output logic                   rsp_hit,
  output logic [2:0]             mem_mode,
  output logic [ID_Width-1:0]    mem_packet_id,
  output logic                   mem_vbe,
  output logic                   mem_dcs,
  output logic                   mem_vbi,
  output logic [2*ID_Width-1:0]  mem_data,
  output logic [2*ID_Width-1:0]  mem_mskb,
  output logic [AddressSize-1:0] mem_addr,
  input  logic [ID_Width-1:0]    mem_dst_id
);

  localparam int BITS  = 2 * ID_Width;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(CMP_WAIT + 1);

  localparam logic [2:0] MODE_I = 3'b000;
  localparam logic [2:0] MODE_W = 3'b001;
  localparam logic [2:0] MODE_F = 3'b011;
  localparam logic [2:0] MODE_C = 3'b100;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_WRITE  = 2'd1;
  localparam logic [1:0] OP_FLUSH  = 2'd2;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPT, RESP} state_t;

  typedef struct packed {
    logic [1:0]             op;
    logic [TAG_W-1:0]       tag;
    logic [ID_Width-1:0]    id;
    logic [BITS-1:0]        data;
    logic [BITS-1:0]        mask;
    logic [AddressSize-1:0] addr;
    logic                   vbi;
  } cmd_t;

  // ---------------- request FIFO ----------------
  cmd_t             fifo_mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             full, empty, push, pop;

  assign full      = (count_reg == (PTR_W + 1)'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign head      = fifo_mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= '{req_op, req_tag, req_id, req_data, req_mask, req_addr, req_vbi};
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- sequencer ----------------
  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [1:0]         op_reg, op_next;
  logic [TAG_W-1:0]   tag_reg, tag_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [TAG_W-1:0]   rsp_tag_reg, rsp_tag_next;
  logic [ID_Width-1:0] rsp_dst_reg, rsp_dst_next;
  logic               rsp_hit_reg, rsp_hit_next;
  logic [2:0]         mode_reg, mode_next;
  logic [ID_Width-1:0] pid_reg, pid_next;
  logic               vbe_reg, vbe_next, dcs_reg, dcs_next, vbi_reg, vbi_next;
  logic [BITS-1:0]    data_reg, data_next, mskb_reg, mskb_next;
  logic [AddressSize-1:0] addr_reg, addr_next;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    tag_next       = tag_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_tag_next   = rsp_tag_reg;
    rsp_dst_next   = rsp_dst_reg;
    rsp_hit_next   = rsp_hit_reg;
    // Mem pins idle unless a command is being loaded for its ISSUE cycle.
    mode_next      = MODE_I;
    pid_next       = '0;
    vbe_next       = 1'b0;
    dcs_next       = 1'b0;
    vbi_next       = 1'b0;
    data_next      = '0;
    mskb_next      = '0;
    addr_next      = '0;
    pop            = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          // Mem pins are registered, so the operands are loaded at the pop
          // edge and are therefore visible throughout the ISSUE cycle.
          pop        = 1'b1;
          op_next    = head.op;
          tag_next   = head.tag;
          state_next = ISSUE;
          case (head.op)
            OP_LOOKUP: begin
              mode_next = MODE_C;
              pid_next  = head.id;
            end
            OP_WRITE: begin
              mode_next = MODE_W;
              vbe_next  = 1'b1;
              dcs_next  = 1'b1;
              vbi_next  = head.vbi;
              data_next = head.data;
              mskb_next = head.mask;
              addr_next = head.addr;
            end
            OP_FLUSH: mode_next = MODE_F;
            default:  mode_next = MODE_I;
          endcase
        end
      end
      ISSUE: begin
        if (op_reg == OP_LOOKUP) begin
          cnt_next   = CNT_W'(CMP_WAIT - 1);
          state_next = WAIT;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT: begin
        if (cnt_reg == '0) state_next = CAPT;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      CAPT: begin
        rsp_valid_next = 1'b1;
        rsp_tag_next   = tag_reg;
        rsp_dst_next   = mem_dst_id;
        rsp_hit_next   = |mem_dst_id;
        state_next     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      op_reg        <= '0;
      tag_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_tag_reg   <= '0;
      rsp_dst_reg   <= '0;
      rsp_hit_reg   <= 1'b0;
      mode_reg      <= MODE_I;
      pid_reg       <= '0;
      vbe_reg       <= 1'b0;
      dcs_reg       <= 1'b0;
      vbi_reg       <= 1'b0;
      data_reg      <= '0;
      mskb_reg      <= '0;
      addr_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      op_reg        <= op_next;
      tag_reg       <= tag_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_tag_reg   <= rsp_tag_next;
      rsp_dst_reg   <= rsp_dst_next;
      rsp_hit_reg   <= rsp_hit_next;
      mode_reg      <= mode_next;
      pid_reg       <= pid_next;
      vbe_reg       <= vbe_next;
      dcs_reg       <= dcs_next;
      vbi_reg       <= vbi_next;
      data_reg      <= data_next;
      mskb_reg      <= mskb_next;
      addr_reg      <= addr_next;
    end
  end

  assign rsp_valid     = rsp_valid_reg;
  assign rsp_tag       = rsp_tag_reg;
  assign rsp_dst       = rsp_dst_reg;
  assign rsp_hit       = rsp_hit_reg;
  assign mem_mode      = mode_reg;
  assign mem_packet_id = pid_reg;
  assign mem_vbe       = vbe_reg;
  assign mem_dcs       = dcs_reg;
  assign mem_vbi       = vbi_reg;
  assign mem_data      = data_reg;
  assign mem_mskb      = mskb_reg;
  assign mem_addr      = addr_reg;

endmodule

// File: tb/tb_tcam_lookup_sched.sv
// Directed bench for tcam_lookup_sched with a tiny Mem model: a written word
// holds key in data[7:4] and destination in data[3:0]; the lowest valid
// address whose key equals PacketID wins, otherwise the result is 0.
module tb_tcam_lookup_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = '0;
  logic [3:0] req_tag = '0;
  logic [3:0] req_id = '0;
  logic [7:0] req_data = '0;
  logic [7:0] req_mask = '0;
  logic [3:0] req_addr = '0;
  logic       req_vbi = 1'b0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_tag;
  logic [3:0] rsp_dst;
  logic       rsp_hit;
  logic [2:0] mem_mode;
  logic [3:0] mem_packet_id;
  logic       mem_vbe, mem_dcs, mem_vbi;
  logic [7:0] mem_data, mem_mskb;
  logic [3:0] mem_addr;
  logic [3:0] mem_dst_id;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tcam_lookup_sched dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_tag(req_tag),
    .req_id(req_id), .req_data(req_data), .req_mask(req_mask), .req_addr(req_addr),
    .req_vbi(req_vbi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_dst(rsp_dst),
    .rsp_hit(rsp_hit),
    .mem_mode(mem_mode), .mem_packet_id(mem_packet_id), .mem_vbe(mem_vbe),
    .mem_dcs(mem_dcs), .mem_vbi(mem_vbi), .mem_data(mem_data), .mem_mskb(mem_mskb),
    .mem_addr(mem_addr), .mem_dst_id(mem_dst_id)
  );

  // ---------------- Mem model ----------------
  logic [3:0] m_key [16];
  logic [3:0] m_dst [16];
  logic       m_v   [16];

  function automatic logic [3:0] model_lookup(input logic [3:0] key);
    logic [3:0] res;
    res = '0;
    for (int i = 15; i >= 0; i--)
      if (m_v[i] && m_key[i] == key) res = m_dst[i];
    return res;
  endfunction

  always @(posedge clk) begin
    if (rst && $time < 20) begin
      for (int i = 0; i < 16; i++) begin
        m_v[i]   <= 1'b0;
        m_key[i] <= '0;
        m_dst[i] <= '0;
      end
      mem_dst_id <= '0;
    end else if (mem_mode == 3'b001 && mem_vbe) begin
      m_key[mem_addr] <= mem_data[7:4];
      m_dst[mem_addr] <= mem_data[3:0];
      m_v[mem_addr]   <= mem_vbi;
    end else if (mem_mode == 3'b011) begin
      for (int i = 0; i < 16; i++) m_v[i] <= 1'b0;
    end else if (mem_mode == 3'b100) begin
      mem_dst_id <= model_lookup(mem_packet_id);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [1:0] op, input logic [3:0] tag, input logic [3:0] id,
                      input logic [7:0] data, input logic [7:0] mask,
                      input logic [3:0] addr, input logic vbi);
    int budget;
    req_op = op; req_tag = tag; req_id = id; req_data = data;
    req_mask = mask; req_addr = addr; req_vbi = vbi; req_valid = 1'b1;
    budget = 0;
    while (!req_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("req_ready_wait", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_mode(input logic [2:0] m);
    for (int i = 0; i < 30 && mem_mode !== m; i++) @(negedge clk);
    check("mode_wait", mem_mode, m);
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 40 && rsp_valid !== 1'b1; i++) @(negedge clk);
    check("rsp_wait", rsp_valid, 1);
  endtask

  logic [3:0] exp_tag [5];
  logic [3:0] exp_dst [5];
  int         bad;

  initial begin
    // 1: reset with req_valid asserted
    req_valid = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_mem_mode", mem_mode, 3'b000);
    check("rst_rsp_dst", rsp_dst, 0);
    check("rst_mem_data", mem_data, 0);

    // 2: write addr3 data 52 mask F0 vbi1 (key 5 -> dst 2)
    send(2'd1, 4'd0, 4'd0, 8'h52, 8'hF0, 4'd3, 1'b1);
    wait_mode(3'b001);
    check("wr_addr", mem_addr, 3);
    check("wr_data", mem_data, 8'h52);
    check("wr_mskb", mem_mskb, 8'hF0);
    check("wr_vbe_dcs_vbi", {mem_vbe, mem_dcs, mem_vbi}, 3'b111);
    @(negedge clk);
    check("wr_mode_after", mem_mode, 3'b000);

    // 3: lookup id5 tag9 -> dst 2, latency CMP_WAIT+2 after ISSUE
    send(2'd0, 4'd9, 4'd5, 8'h00, 8'h00, 4'd0, 1'b0);
    wait_mode(3'b100);
    check("lk_pid", mem_packet_id, 5);
    check("lk_vbe_dcs_vbi", {mem_vbe, mem_dcs, mem_vbi}, 3'b000);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) check("lk_mode_one_cycle", mem_mode, 3'b000);
      check($sformatf("lk_rsp_valid_c%0d", i), rsp_valid, (i == 4) ? 1 : 0);
    end
    check("lk_tag", rsp_tag, 9);
    check("lk_dst", rsp_dst, 2);
    check("lk_hit", rsp_hit, 1);
    @(negedge clk);
    check("lk_rsp_drop", rsp_valid, 0);

    // 4: lookup miss
    send(2'd0, 4'd3, 4'd7, 8'h00, 8'h00, 4'd0, 1'b0);
    wait_rsp();
    check("miss_tag", rsp_tag, 3);
    check("miss_dst", rsp_dst, 0);
    check("miss_hit", rsp_hit, 0);
    @(negedge clk);

    // 5: fill FIFO with rsp_ready low, then drain in order
    send(2'd1, 4'd0, 4'd0, 8'h63, 8'h00, 4'd4, 1'b1);   // key 6 -> dst 3
    send(2'd1, 4'd0, 4'd0, 8'h71, 8'h00, 4'd5, 1'b1);   // key 7 -> dst 1
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
    exp_tag = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    exp_dst = '{4'd2, 4'd3, 4'd1, 4'd0, 4'd2};
    send(2'd0, 4'd1, 4'd5, 8'h0, 8'h0, 4'd0, 1'b0);
    send(2'd0, 4'd2, 4'd6, 8'h0, 8'h0, 4'd0, 1'b0);
    send(2'd0, 4'd3, 4'd7, 8'h0, 8'h0, 4'd0, 1'b0);
    send(2'd0, 4'd4, 4'd9, 8'h0, 8'h0, 4'd0, 1'b0);
    send(2'd0, 4'd5, 4'd5, 8'h0, 8'h0, 4'd0, 1'b0);
    check("full_req_ready", req_ready, 0);
    wait_rsp();
    repeat (3) @(negedge clk);
    check("hold_valid", rsp_valid, 1);
    check("hold_tag", rsp_tag, 1);
    check("hold_dst", rsp_dst, 2);
    check("hold_req_ready", req_ready, 0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rsp();
      check($sformatf("drain%0d_tag", i), rsp_tag, exp_tag[i]);
      check($sformatf("drain%0d_dst", i), rsp_dst, exp_dst[i]);
      @(negedge clk);
    end

    // 6: reset during WAIT with a write queued behind the lookup
    send(2'd0, 4'd6, 4'd5, 8'h0, 8'h0, 4'd0, 1'b0);
    send(2'd1, 4'd0, 4'd0, 8'hA1, 8'h00, 4'd9, 1'b1);
    wait_mode(3'b100);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rstw_mode", mem_mode, 3'b000);
    check("rstw_rsp_valid", rsp_valid, 0);
    check("rstw_req_ready", req_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_mode !== 3'b000) bad++;
    end
    check("rstw_quiet_cycles", bad, 0);

    // reserved op is dropped without driving Mem
    send(2'd3, 4'd0, 4'd5, 8'hFF, 8'hFF, 4'd1, 1'b1);
    bad = 0;
    repeat (5) begin
      if (mem_mode !== 3'b000 || rsp_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    check("op3_quiet_cycles", bad, 0);

    // flush, then the earlier hit becomes a miss
    send(2'd2, 4'd0, 4'd0, 8'hFF, 8'hFF, 4'd2, 1'b1);
    wait_mode(3'b011);
    check("fl_operands", {mem_data, mem_mskb, mem_addr, mem_vbe}, 0);
    @(negedge clk);
    send(2'd0, 4'd8, 4'd5, 8'h0, 8'h0, 4'd0, 1'b0);
    wait_rsp();
    check("fl_tag", rsp_tag, 8);
    check("fl_dst", rsp_dst, 0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
